// File: rtl/instr_mem_pipe_if.sv
// Fetch/write port bundle for instr_mem_pipe.
// master = requester/writer side, slave = memory side.
interface instr_mem_pipe_if #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 32
);
  localparam int NB = DATA_W / 8;

  logic              f_req_valid;
  logic              f_req_ready;
  logic [ADDR_W-1:0] f_addr;
  logic              f_rsp_valid;
  logic              f_rsp_ready;
  logic [DATA_W-1:0] f_rsp_data;
  logic              f_rsp_err;
  logic              w_en;
  logic [ADDR_W-1:0] w_addr;
  logic [DATA_W-1:0] w_data;
  logic [NB-1:0]     w_be;

  modport master (
    output f_req_valid, f_addr, f_rsp_ready, w_en, w_addr, w_data, w_be,
    input  f_req_ready, f_rsp_valid, f_rsp_data, f_rsp_err
  );

  modport slave (
    input  f_req_valid, f_addr, f_rsp_ready, w_en, w_addr, w_data, w_be,
    output f_req_ready, f_rsp_valid, f_rsp_data, f_rsp_err
  );
endinterface

// File: rtl/instr_mem_pipe.sv
// Byte-addressed instruction memory with a one-deep registered fetch response.
// Define IMEM_MISALIGN_TRAP_EN to flag misaligned fetches instead of aligning them.

// Byte address of one lane for a word starting at base; wraps at 2**ADDR_W.
module instr_mem_pipe_lane #(
  parameter int ADDR_W     = 12,
  parameter int NB         = 4,
  parameter int LANE       = 0,
  parameter int BIG_ENDIAN = 1
) (
  input  logic [ADDR_W-1:0] base,
  output logic [ADDR_W-1:0] addr
);
  localparam int OFS = (BIG_ENDIAN != 0) ? (NB - 1 - LANE) : LANE;
  assign addr = base + ADDR_W'(OFS);
endmodule

module instr_mem_pipe #(
  parameter int ADDR_W     = 12,
  parameter int DATA_W     = 32,
  parameter int BIG_ENDIAN = 1
) (
  input logic              clk,
  input logic              rst_n,
  instr_mem_pipe_if.slave  bus
);
  localparam int NB    = DATA_W / 8;
  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [ADDR_W-1:0] LOW_MASK = ADDR_W'(NB - 1);

  logic [7:0] mem_q [DEPTH];

  logic [ADDR_W-1:0]           f_base;
  logic                        mis;
  logic [NB-1:0][ADDR_W-1:0]   f_lane_addr;
  logic [NB-1:0][ADDR_W-1:0]   w_lane_addr;
  logic [NB-1:0][7:0]          rd_word;

  logic              rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0] rsp_data_q,  rsp_data_d;
  logic              rsp_err_q,   rsp_err_d;
  logic              req_ready;
  logic              accept;

`ifdef IMEM_MISALIGN_TRAP_EN
  assign f_base = bus.f_addr;
  assign mis    = |(bus.f_addr & LOW_MASK);
`else
  assign f_base = bus.f_addr & ~LOW_MASK;
  assign mis    = 1'b0;
`endif

  for (genvar k = 0; k < NB; k++) begin : g_lane
    instr_mem_pipe_lane #(
      .ADDR_W(ADDR_W), .NB(NB), .LANE(k), .BIG_ENDIAN(BIG_ENDIAN)
    ) u_f (.base(f_base), .addr(f_lane_addr[k]));
    instr_mem_pipe_lane #(
      .ADDR_W(ADDR_W), .NB(NB), .LANE(k), .BIG_ENDIAN(BIG_ENDIAN)
    ) u_w (.base(bus.w_addr), .addr(w_lane_addr[k]));
    assign rd_word[k] = mem_q[f_lane_addr[k]];
  end

  // Response register is the only stage, so ready never looks past it.
  always_comb begin
    req_ready   = !rsp_valid_q || bus.f_rsp_ready;
    accept      = bus.f_req_valid && req_ready;
    rsp_valid_d = rsp_valid_q;
    rsp_data_d  = rsp_data_q;
    rsp_err_d   = rsp_err_q;
    if (accept) begin
      rsp_valid_d = 1'b1;
      rsp_data_d  = mis ? '0 : DATA_W'(rd_word);
      rsp_err_d   = mis;
    end else if (bus.f_rsp_ready) begin
      rsp_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  // Array is never reset; the fetch above samples it before this edge lands.
  always_ff @(posedge clk) begin
    if (rst_n && bus.w_en) begin
      for (int k = 0; k < NB; k++) begin
        if (bus.w_be[k]) mem_q[w_lane_addr[k]] <= bus.w_data[k*8 +: 8];
      end
    end
  end

  assign bus.f_req_ready = req_ready;
  assign bus.f_rsp_valid = rsp_valid_q;
  assign bus.f_rsp_data  = rsp_data_q;
  assign bus.f_rsp_err   = rsp_err_q;
endmodule
